// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin sequencer for the shared ALU
//
// Purpose: accepts one operation at a time from two requesters, drives the
// combinational ALU from captured registers, waits a per-opcode settle time,
// registers the result and returns it to the requester that issued it.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   reqN_valid/ready      operation handshake (ready only in IDLE, for the grantee)
//   reqN_a/b/op           operands and opcode (0=XOR 1=ADD 2=MUL low byte 3=SUB)
//   respN_valid/ready     result handshake
//   respN_data            result, held until the next result for that requester
//   alu_a/alu_b/alu_op    registered ALU inputs
//   alu_rout              combinational ALU result
//   busy                  high whenever not IDLE
//   done_count            completed responses, wraps
module alu_arbiter #(
  parameter int WIDTH       = 16,
  parameter int EXEC_CYCLES = 1,
  parameter int MUL_CYCLES  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  output logic             resp0_valid,
  output logic [WIDTH-1:0] resp0_data,
  input  logic             resp0_ready,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp1_data,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_rout,
  output logic             busy,
  output logic [7:0]       done_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic             owner_q, owner_d;
  logic             rr_last_q, rr_last_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             resp0_valid_q, resp0_valid_d;
  logic             resp1_valid_q, resp1_valid_d;
  logic [WIDTH-1:0] resp0_data_q, resp0_data_d;
  logic [WIDTH-1:0] resp1_data_q, resp1_data_d;
  logic [7:0]       done_count_q, done_count_d;

  logic             grant0, grant1;
  logic [WIDTH-1:0] result;
  logic [1:0]       sel_op;
  logic             resp_hs;

  // rr_last_q names the requester served most recently; on contention the
  // other one wins, so reset value 1 gives requester 0 the first grant.
  assign grant0     = req0_valid && (!req1_valid || rr_last_q);
  assign grant1     = req1_valid && (!req0_valid || !rr_last_q);
  assign req0_ready = (state_q == IDLE) && grant0;
  assign req1_ready = (state_q == IDLE) && grant1;

  // MUL only yields a valid low byte; the upper byte is forced to zero.
  assign result  = (alu_op_q == 2'd2) ? {{(WIDTH-8){1'b0}}, alu_rout[7:0]} : alu_rout;
  assign sel_op  = req1_ready ? req1_op : req0_op;
  assign resp_hs = owner_q ? (resp1_valid_q && resp1_ready) : (resp0_valid_q && resp0_ready);

  always_comb begin
    state_d       = state_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    owner_d       = owner_q;
    rr_last_d     = rr_last_q;
    cnt_d         = cnt_q;
    resp0_valid_d = resp0_valid_q;
    resp1_valid_d = resp1_valid_q;
    resp0_data_d  = resp0_data_q;
    resp1_data_d  = resp1_data_q;
    done_count_d  = done_count_q;
    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          alu_a_d   = req1_ready ? req1_a : req0_a;
          alu_b_d   = req1_ready ? req1_b : req0_b;
          alu_op_d  = sel_op;
          owner_d   = req1_ready;
          rr_last_d = req1_ready;
          cnt_d     = (sel_op == 2'd2) ? 8'(MUL_CYCLES) : 8'(EXEC_CYCLES);
          state_d   = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          if (owner_q) begin
            resp1_data_d  = result;
            resp1_valid_d = 1'b1;
          end else begin
            resp0_data_d  = result;
            resp0_valid_d = 1'b1;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_hs) begin
          resp0_valid_d = 1'b0;
          resp1_valid_d = 1'b0;
          done_count_d  = done_count_q + 8'd1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= 2'd0;
      owner_q       <= 1'b0;
      rr_last_q     <= 1'b1;
      cnt_q         <= 8'd0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_data_q  <= '0;
      resp1_data_q  <= '0;
      done_count_q  <= 8'd0;
    end else begin
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      owner_q       <= owner_d;
      rr_last_q     <= rr_last_d;
      cnt_q         <= cnt_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      resp0_data_q  <= resp0_data_d;
      resp1_data_q  <= resp1_data_d;
      done_count_q  <= done_count_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp0_data  = resp0_data_q;
  assign resp1_data  = resp1_data_q;
  assign busy        = (state_q != IDLE);
  assign done_count  = done_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, resp0_valid, resp0_ready;
  logic        req1_valid, req1_ready, resp1_valid, resp1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b, resp0_data, resp1_data;
  logic [1:0]  req0_op, req1_op, alu_op;
  logic [15:0] alu_a, alu_b, alu_rout;
  logic        busy;
  logic [7:0]  done_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_done = 0;
  logic [15:0] exp_tab [4] = '{16'h0101, 16'h0220, 16'h0103, 16'h0240};

  always #5 clk = ~clk;

  // Intended ALU function; MUL returns the full 16-bit product so the
  // arbiter's low-byte masking is exercised.
  always_comb begin
    case (alu_op)
      2'd0:    alu_rout = alu_a ^ alu_b;
      2'd1:    alu_rout = alu_a + alu_b;
      2'd2:    alu_rout = alu_a * alu_b;
      default: alu_rout = alu_a - alu_b;
    endcase
  end

  alu_arbiter #(.WIDTH(16), .EXEC_CYCLES(1), .MUL_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .resp0_valid(resp0_valid), .resp0_data(resp0_data), .resp0_ready(resp0_ready),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .resp1_valid(resp1_valid), .resp1_data(resp1_data), .resp1_ready(resp1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_rout(alu_rout),
    .busy(busy), .done_count(done_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at posedge+1 in IDLE; returns at posedge+1 back in IDLE.
  task automatic run_op(input bit who, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] op, input logic [15:0] exp, input int lat);
    if (who) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    else     begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    @(negedge clk);
    check_eq("ready_own", who ? req1_ready : req0_ready, 1);
    check_eq("ready_other", who ? req0_ready : req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 16'hDEAD; req1_a = 16'hBEEF;
    check_eq("alu_op", alu_op, op);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      check_eq("exec_no_resp", {resp1_valid, resp0_valid}, 0);
      check_eq("exec_busy", busy, 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_eq("resp_valid", who ? resp1_valid : resp0_valid, 1);
    check_eq("resp_data", who ? resp1_data : resp0_data, exp);
    check_eq("resp_other", who ? resp0_valid : resp1_valid, 0);
    if (who) resp1_ready = 1'b1; else resp0_ready = 1'b1;
    @(posedge clk); #1;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    exp_done++;
    @(negedge clk);
    check_eq("idle_after", busy, 0);
    check_eq("done_count", done_count, exp_done);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
    req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_alu", {alu_a, alu_b}, 0);
    check_eq("rst_op", alu_op, 0);
    check_eq("rst_resp", {resp1_valid, resp0_valid, resp0_data, resp1_data}, 0);
    check_eq("rst_done", done_count, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(0, 16'h1234, 16'h0101, 2'd1, 16'h1335, 1);
    run_op(1, 16'h0005, 16'h0007, 2'd3, 16'hFFFE, 1);
    check_eq("nonowner_keep", resp0_data, 16'h1335);
    run_op(1, 16'hFF00, 16'h0FF0, 2'd0, 16'hF0F0, 1);
    run_op(0, 16'hAB12, 16'h0034, 2'd2, 16'h00A8, 2);
    check_eq("nonowner_keep1", resp1_data, 16'hF0F0);

    // Both requesters valid from reset: strict alternation starting with 0.
    rst_n = 1'b0;
    exp_done = 0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_op = 2'd1; req1_op = 2'd1;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req0_a = 16'(k + 1);        req0_b = 16'h0100;
      req1_a = 16'(16 * (k + 1)); req1_b = 16'h0200;
      @(negedge clk);
      check_eq("rr_ready0", req0_ready, (k % 2) == 0);
      check_eq("rr_ready1", req1_ready, (k % 2) == 1);
      check_eq("rr_onehot", req0_ready & req1_ready, 0);
      @(posedge clk); #1;
      if (k % 2) req1_a = 16'hDEAD; else req0_a = 16'hDEAD;
      @(negedge clk);
      check_eq("rr_exec_ready", {req1_ready, req0_ready}, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("rr_valid", (k % 2) ? {resp1_valid, resp0_valid} : {resp0_valid, resp1_valid}, 2'b10);
      check_eq("rr_data", (k % 2) ? resp1_data : resp0_data, exp_tab[k]);
      if (k % 2) resp1_ready = 1'b1; else resp0_ready = 1'b1;
      @(posedge clk); #1;
      resp0_ready = 1'b0; resp1_ready = 1'b0;
      exp_done++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check_eq("rr_done", done_count, exp_done);

    // Response back-pressure with a competing request pending.
    req0_valid = 1'b1; req0_a = 16'h00FF; req0_b = 16'h0F0F; req0_op = 2'd0;
    @(negedge clk);
    check_eq("bp_accept", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h0002; req1_b = 16'h0003; req1_op = 2'd1;
    @(negedge clk);
    check_eq("bp_exec_ready", req1_ready, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_valid", resp0_valid, 1);
      check_eq("bp_data", resp0_data, 16'h0FF0);
      check_eq("bp_ready", {req1_ready, req0_ready}, 0);
      @(posedge clk); #1;
    end
    resp0_ready = 1'b1;
    @(posedge clk); #1;
    resp0_ready = 1'b0;
    exp_done++;
    @(negedge clk);
    check_eq("bp_idle", busy, 0);
    check_eq("bp_cleared", resp0_valid, 0);
    check_eq("bp_next_ready", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_next_alu", alu_a, 16'h0002);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("bp_next_data", resp1_data, 16'h0005);
    resp1_ready = 1'b1;
    @(posedge clk); #1;
    resp1_ready = 1'b0;
    exp_done++;
    check_eq("bp_done", done_count, exp_done);

    // Reset in the middle of EXEC after a req0 grant.
    req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h2222; req0_op = 2'd1;
    @(negedge clk);
    check_eq("rst_accept", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_alu", {alu_a, alu_b, 14'd0, alu_op}, 0);
    check_eq("arst_resp", {resp1_valid, resp0_valid}, 0);
    check_eq("arst_done", done_count, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("arst_no_resp", {resp1_valid, resp0_valid, busy}, 0);
      @(posedge clk); #1;
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check_eq("arst_grant0", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
